// File: rtl/stopwatch_pkg.sv
// Shared encodings and defaults for the stopwatch control slice.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned NUM_DIGITS     = 4;
  localparam int unsigned VAL_W          = DIGIT_W * NUM_DIGITS;
  localparam logic [15:0] MAX_BCD_DEF    = 16'h9999;
  localparam int unsigned DEB_CYCLES_DEF = 10_000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_LAP   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_LAP   = ST_LAP,
    S_PAUSE = ST_PAUSE,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to one-cycle press pulse: 2-FF synchroniser, stability
// counter, then a registered rising-edge detect on the debounced level.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PRESS
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stability counter: any return to the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, debounced level and press pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= BTN;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign PRESS = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button commands, counter-chain enable/clear,
// lap snapshot and display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned      DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic [VAL_W-1:0] MAX_BCD    = MAX_BCD_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_SS,
  input  logic             BTN_LR,
  input  logic [VAL_W-1:0] CNT_VAL,
  output logic             CNT_EN,
  output logic             CNT_CLR,
  output logic [VAL_W-1:0] DISP_VAL,
  output logic             RUNNING,
  output logic             LAP_ACT,
  output logic             DONE
);

  logic             ss_p, lr_p;
  logic             at_max_s;
  state_t           state_q;
  logic [VAL_W-1:0] lap_q;
  logic             clr_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN_SS),
    .PRESS (ss_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN_LR),
    .PRESS (lr_p)
  );

  assign at_max_s = (CNT_VAL == MAX_BCD);

  // Command FSM; ss is tested before lr so a simultaneous lr is dropped,
  // and full scale is tested before either in RUN/LAP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      lap_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ss_p) begin
            state_q <= S_RUN;
          end else if (lr_p) begin
            clr_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (at_max_s) begin
            state_q <= S_DONE;
          end else if (ss_p) begin
            state_q <= S_PAUSE;
          end else if (lr_p) begin
            state_q <= S_LAP;
            lap_q   <= CNT_VAL;
          end
        end
        S_LAP: begin
          if (at_max_s) begin
            state_q <= S_DONE;
          end else if (ss_p) begin
            state_q <= S_PAUSE;
          end else if (lr_p) begin
            state_q <= S_RUN;
          end
        end
        S_PAUSE: begin
          if (ss_p) begin
            state_q <= S_RUN;
          end else if (lr_p) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b1;
          end
        end
        S_DONE: begin
          if (lr_p) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RUNNING  = (state_q == S_RUN) || (state_q == S_LAP);
  assign LAP_ACT  = (state_q == S_LAP);
  assign DONE     = (state_q == S_DONE);
  // Gated on full scale so the chain can never wrap past 9999.
  assign CNT_EN   = RUNNING && !at_max_s;
  assign CNT_CLR  = clr_q;
  assign DISP_VAL = LAP_ACT ? lap_q : CNT_VAL;

endmodule
